counter_b4_monitor: RTL

- Passive receiving-end checker for the 4-bit mode counter interface: enable, mode, D in; Q, load, rco out.
- Observes the commands driven into the counter and the counter's responses, and holds a reference model of the expected count.
- Flags every mismatch, counts errors, and latches a fault state.
- Sits beside the counter in layout test harnesses and in the silicon self-check path.

---
 rtl/counter_b4_pkg.sv | 23 ++
 rtl/counter_b4_model.sv | 40 ++++
 rtl/counter_b4_monitor.sv | 132 +++++++++++++
 3 files changed

// File: rtl/counter_b4_pkg.sv
// Shared definitions for the 4-bit mode counter and its receiving-end monitor.
package counter_b4_pkg;

    localparam logic [1:0] MODE_UP  = 2'b00;
    localparam logic [1:0] MODE_DN  = 2'b01;
    localparam logic [1:0] MODE_DN3 = 2'b10;
    localparam logic [1:0] MODE_LD  = 2'b11;

    typedef enum logic [1:0] {
        UNSYNC = 2'd0,
        TRACK  = 2'd1,
        FAULT  = 2'd2
    } mon_state_e;

    // One captured command plus the model value it applies to.
    typedef struct packed {
        logic       enable;
        logic [1:0] mode;
        logic [3:0] d;
        logic [3:0] base;
    } cmd_t;

endpackage

// File: rtl/counter_b4_model.sv
// Combinational predictor: counter response to one command from a known Q.
module counter_b4_model
    import counter_b4_pkg::*;
(
    input  logic       enable,
    input  logic [1:0] mode,
    input  logic [3:0] d,
    input  logic [3:0] cur_q,
    output logic [3:0] next_q,
    output logic       load,
    output logic       rco
);

    always_comb begin
        next_q = cur_q;
        load   = 1'b0;
        rco    = 1'b0;
        if (enable) begin
            case (mode)
                MODE_UP: begin
                    next_q = cur_q + 4'd1;
                    rco    = (cur_q == 4'd15);
                end
                MODE_DN: begin
                    next_q = cur_q - 4'd1;
                    rco    = (cur_q == 4'd0);
                end
                MODE_DN3: begin
                    next_q = cur_q - 4'd3;
                    rco    = (cur_q <= 4'd2);
                end
                default: begin
                    next_q = d;
                    load   = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/counter_b4_monitor.sv
// Passive checker for the 4-bit mode counter: predicts Q/load/rco one cycle
// after each command, flags mismatches, counts them and latches a fault.
module counter_b4_monitor
    import counter_b4_pkg::*;
#(
    parameter int unsigned ERR_W     = 8,
    parameter int unsigned ERR_LIMIT = 4,
    parameter bit          CHECK_RCO = 1'b1
) (
    input  logic             b4_clk,
    input  logic             b4_reset,
    input  logic             mon_enable,
    input  logic [1:0]       mon_mode,
    input  logic [3:0]       mon_D,
    input  logic [3:0]       mon_Q,
    input  logic             mon_load,
    input  logic             mon_rco,
    input  logic             mon_clear,
    output logic             mon_locked,
    output logic             mon_err,
    output logic [ERR_W-1:0] mon_err_count,
    output logic             mon_fault,
    output logic [3:0]       mon_exp_Q
);

    localparam logic [ERR_W-1:0] LIMIT = ERR_LIMIT[ERR_W-1:0];

    mon_state_e       state_q, state_d;
    cmd_t             c1_q, c1_d;
    logic             c1_valid_q, c1_valid_d;
    logic             valid_q, valid_d;
    logic [3:0]       exp_val_q, exp_val_d;
    logic             err_q, err_d;
    logic [ERR_W-1:0] cnt_q, cnt_d;

    logic [3:0] pred_q;
    logic       pred_load, pred_rco;
    logic       q_chk, ld_chk, rco_chk, q_mis, mismatch;

    counter_b4_model u_model (
        .enable (c1_q.enable),
        .mode   (c1_q.mode),
        .d      (c1_q.d),
        .cur_q  (c1_q.base),
        .next_q (pred_q),
        .load   (pred_load),
        .rco    (pred_rco)
    );

    always_comb begin
        // Without a valid model rco is only predictable for idle and load commands.
        q_chk    = c1_valid_q & c1_q.enable & valid_q;
        ld_chk   = c1_valid_q;
        rco_chk  = c1_valid_q & CHECK_RCO
                 & (valid_q | ~c1_q.enable | (c1_q.mode == MODE_LD));
        q_mis    = q_chk & (mon_Q != pred_q);
        mismatch = q_mis
                 | (ld_chk  & (mon_load != pred_load))
                 | (rco_chk & (mon_rco  != pred_rco));

        valid_d   = valid_q;
        exp_val_d = exp_val_q;
        if (c1_valid_q) begin
            if (!c1_q.enable) begin
                valid_d = 1'b0;
            end else if (valid_q) begin
                exp_val_d = q_mis ? mon_Q : pred_q;
            end else if (c1_q.mode == MODE_LD) begin
                valid_d   = 1'b1;
                exp_val_d = c1_q.d;
            end
        end

        if (mon_clear) begin
            cnt_d = '0;
        end else if (mismatch && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end else begin
            cnt_d = cnt_q;
        end

        state_d = state_q;
        case (state_q)
            UNSYNC: if (valid_d) state_d = TRACK;
            TRACK: begin
                if (cnt_d >= LIMIT) begin
                    state_d = FAULT;
                end else if (!valid_d) begin
                    state_d = UNSYNC;
                end
            end
            FAULT: if (mon_clear) state_d = valid_d ? TRACK : UNSYNC;
            default: state_d = UNSYNC;
        endcase

        // New command is based on the value the model settles to at this edge,
        // so back-to-back commands each see the counter's current Q.
        c1_d.enable = mon_enable;
        c1_d.mode   = mon_mode;
        c1_d.d      = mon_D;
        c1_d.base   = exp_val_d;
        c1_valid_d  = 1'b1;
        err_d       = mismatch;
    end

    always_ff @(posedge b4_clk) begin
        if (b4_reset) begin
            state_q    <= UNSYNC;
            c1_q       <= '0;
            c1_valid_q <= 1'b0;
            valid_q    <= 1'b0;
            exp_val_q  <= '0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            c1_q       <= c1_d;
            c1_valid_q <= c1_valid_d;
            valid_q    <= valid_d;
            exp_val_q  <= exp_val_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
        end
    end

    assign mon_locked    = (state_q != UNSYNC);
    assign mon_err       = err_q;
    assign mon_err_count = cnt_q;
    assign mon_fault     = (state_q == FAULT);
    assign mon_exp_Q     = exp_val_q;

endmodule
